ctr64_display: RTL

CTR64_DISPLAY -- requirements
Module: ctr64_display

---
 rtl/ctr64_display.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ctr64_display.sv
// ctr64_display: captures a 6-bit upstream count, flags 63->0 wraps, and
// scans the count (and optionally a wrap counter) onto a 4-digit 7-segment
// display. Define WRAP_COUNT_EN to build the wrap counter shown on digit 2.
module ctr64_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [3:0] rg_a,
  input  logic [1:0] bit_a,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       wrap,
  output logic [3:0] wrap_cnt
);

  localparam logic [15:0] PrescLast = 16'(SCAN_DIV - 1);

  logic [5:0]  v;
  logic [5:0]  cap_q;
  logic        wrap_q;
  logic        wrap_hit;
  logic [15:0] presc_q;
  logic [1:0]  idx_q;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0:    p = 7'b1000000;
      4'h1:    p = 7'b1111001;
      4'h2:    p = 7'b0100100;
      4'h3:    p = 7'b0110000;
      4'h4:    p = 7'b0011001;
      4'h5:    p = 7'b0010010;
      4'h6:    p = 7'b0000010;
      4'h7:    p = 7'b1111000;
      4'h8:    p = 7'b0000000;
      4'h9:    p = 7'b0010000;
      4'hA:    p = 7'b0001000;
      4'hB:    p = 7'b0000011;
      4'hC:    p = 7'b1000110;
      4'hD:    p = 7'b0100001;
      4'hE:    p = 7'b0000110;
      default: p = 7'b0001110;
    endcase
    return p;
  endfunction

  assign v = {bit_a, rg_a};
  // An upstream reset from 63 looks identical to a real wrap and counts as one.
  assign wrap_hit = (cap_q == 6'd63) && (v == 6'd0);

  // Capture the upstream count and generate the one-cycle wrap pulse.
  always_ff @(posedge clock) begin
    if (rst) begin
      cap_q  <= 6'd0;
      wrap_q <= 1'b0;
    end else begin
      cap_q  <= v;
      wrap_q <= wrap_hit;
    end
  end

`ifdef WRAP_COUNT_EN
  logic [3:0] wrap_cnt_q;

  // Count wraps modulo 16, rolling over without saturation.
  always_ff @(posedge clock) begin
    if (rst) begin
      wrap_cnt_q <= 4'd0;
    end else if (wrap_hit) begin
      wrap_cnt_q <= wrap_cnt_q + 4'd1;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`else
  assign wrap_cnt = 4'd0;
`endif

  // Prescaler; the digit index advances on its terminal count.
  always_ff @(posedge clock) begin
    if (rst) begin
      presc_q <= 16'd0;
      idx_q   <= 2'd0;
    end else if (presc_q == PrescLast) begin
      presc_q <= 16'd0;
      idx_q   <= idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end

  // Select the source and anode for the current digit.
  always_comb begin
    seg_d = 7'b1111111;
    an_d  = 4'b1111;
    unique case (idx_q)
      2'd0: begin
        seg_d = hex7(cap_q[3:0]);
        an_d  = 4'b1110;
      end
      2'd1: begin
        seg_d = hex7({2'b00, cap_q[5:4]});
        an_d  = 4'b1101;
      end
      2'd2: begin
`ifdef WRAP_COUNT_EN
        seg_d = hex7(wrap_cnt);
`else
        seg_d = 7'b1111111;
`endif
        an_d  = 4'b1011;
      end
      default: begin
        seg_d = 7'b1111111;
        an_d  = 4'b0111;
      end
    endcase
  end

  // Register display outputs; reset blanks everything.
  always_ff @(posedge clock) begin
    if (rst) begin
      seg_q <= 7'b1111111;
      an_q  <= 4'b1111;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign wrap = wrap_q;

endmodule
